nibble_serial_addsub: RTL
=========================

// Module: nibble_serial_addsub
// PURPOSE
//  Multi-word add/subtract engine built on a 4-bit add/sub slice, iterated over NIBBLES nibbles, LSB first.
//  Sits directly downstream of the 4-bit add/sub datapath stage and widens it to W = 4*NIBBLES bits.
//  Registers carry between nibbles and exposes a start/busy/done handshake to the controller above.
//  Arithmetic convention: sub=0 -> A+B; sub=1 -> A-B two's complement; carry_out=1 on subtract = no borrow.
// PARAMETERS
//  NIBBLES  4  operand width in nibbles (>=1); W = 4*NIBBLES is a derived localparam.
// PORTS
//  clk        in   1  single clock, rising edge
//  rst_n      in   1  asynchronous, active-low reset
//  start      in   1  request; sampled only when busy=0
//  sub        in   1  0=add, 1=subtract; latched on accept
//  op_a       in   W  operand A; latched on accept
//  op_b       in   W  operand B; latched on accept
//  busy       out  1  operation in progress
//  done       out  1  one-cycle pulse; result/flags valid from this cycle
//  result     out  W  sum/difference; holds until the next done
//  carry_out  out  1  carry out of the MSB nibble
//  overflow   out  1  signed overflow of the W-bit operation
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; busy, done, result, carry_out, overflow, nibble index, carry reg all 0.
//  FSM: IDLE -> RUN on accepted start; RUN -> IDLE on the edge that processes nibble NIBBLES-1.
//  Accept: start=1 && state==IDLE at edge k. Latch op_a, op_b, sub; carry reg <= sub; index <= 0; busy=1.
//  RUN, edge k+1+i (i=0..NIBBLES-1):
//    {c,s} = a[i] + (b[i] ^ {4{sub}}) + carry reg; work[4i+:4] <= s; carry reg <= c; index++.
//  Edge k+NIBBLES: busy<=0; done<=1 for one cycle.
//    result<=work; carry_out<=final c; overflow <= (a_msb == b'_msb) && (s_msb != a_msb), where b' = b^sub.
//  Latency: done high NIBBLES cycles after the accept edge.
//  result/carry_out/overflow update only at the done edge (atomic); they never show partial nibbles.
//  start while busy: ignored; latched operands are not disturbed.
//  start during the done cycle (state already IDLE): accepted. Back-to-back throughput is one op per NIBBLES cycles.
//  Operand inputs may change freely after the accept edge.
//  Reset mid-operation: operation discarded; no done; all outputs 0; the next start behaves normally.
//  Index wraps never occur; width = max(1, $clog2(NIBBLES)).
//  With NIBBLES=1, result matches the bare 4-bit slice, carry_out included.
// STRUCTURE
//  Shared header addsub_defs.vh: NIBBLE_W=4, FSM state encodings (IDLE=1'b0, RUN=1'b1).
//  One sub-module, nibble_add_cin: combinational 4-bit adder with carry-in.
//    Ports: a[4], b[4], cin -> s[4], cout. Instantiated once and time-multiplexed across nibbles.
//  Top holds the FSM, index counter, carry reg, operand regs, work reg and output regs.
// TESTING
//  1. Assert rst_n=0 -> busy, done, result, carry_out, overflow all 0 with no clock edge.
//  2. A=0x1234, B=0x0FCD, sub=0, start one cycle -> busy high 4 cycles; done pulse exactly 4 cycles after accept;
//     result=0x2201, carry_out=0, overflow=0.
//  3. A=0xFFFF+B=0x0001 -> 0x0000, c=1, ovf=0.
//     A=0x7FFF+B=0x0001 -> 0x8000, c=0, ovf=1.
//     A=0x0005-B=0x0007 -> 0xFFFE, c=0, ovf=0.
//     A=0x8000-B=0x0001 -> 0x7FFF, c=1, ovf=1.
//  4. Pulse start again 2 cycles after accept with different operands -> ignored; first result unchanged.
//     Start asserted in the done cycle -> second op accepted; its done follows 4 cycles later with the correct value.
//  5. Drop rst_n after 2 nibbles of 0x1234+0x0FCD -> outputs 0, no done.
//     Release and rerun -> 0x2201.
//  6. NIBBLES=1 build: exhaustive sweep, A,B in 0..15 x sub in {0,1} (512 ops).
//     Check against the golden model {c,s} = A + (B^{4{sub}}) + sub, plus overflow, every done.

Source files
------------

// File: rtl/nibble_serial_addsub_pkg.sv
// Shared definitions for the nibble-serial add/subtract engine.
package nibble_serial_addsub_pkg;

  localparam int unsigned NibbleW = 4;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StRun  = 1'b1
  } state_e;

endpackage

// File: rtl/nibble_add_cin.sv
// Combinational 4-bit adder with carry-in; the single slice reused for every nibble.
module nibble_add_cin
  import nibble_serial_addsub_pkg::*;
(
  input  logic [NibbleW-1:0] a_i,
  input  logic [NibbleW-1:0] b_i,
  input  logic               cin_i,
  output logic [NibbleW-1:0] s_o,
  output logic               cout_o
);

  logic [NibbleW:0] sum;

  // Widen to NibbleW+1 bits so the carry falls out of the top bit.
  always_comb begin
    sum    = {1'b0, a_i} + {1'b0, b_i} + {{NibbleW{1'b0}}, cin_i};
    s_o    = sum[NibbleW-1:0];
    cout_o = sum[NibbleW];
  end

endmodule

// File: rtl/nibble_serial_addsub.sv
// Multi-word add/subtract, one nibble per cycle LSB first, with start/busy/done handshake.
// sub=1 computes A-B as A + ~B + 1; carry_out=1 on subtract means no borrow.
module nibble_serial_addsub
  import nibble_serial_addsub_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       start_i,
  input  logic                       sub_i,
  input  logic [NibbleW*NIBBLES-1:0] op_a_i,
  input  logic [NibbleW*NIBBLES-1:0] op_b_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [NibbleW*NIBBLES-1:0] result_o,
  output logic                       carry_out_o,
  output logic                       overflow_o
);

  localparam int unsigned W    = NibbleW * NIBBLES;
  localparam int unsigned IdxW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NIBBLES - 1);

  state_e            state_q;
  logic [IdxW-1:0]   idx_q;
  logic              carry_q;
  logic              sub_q;
  logic [W-1:0]      a_q, b_q, work_q, work_d;
  logic              busy_q, done_q, carry_out_q, overflow_q;
  logic [W-1:0]      result_q;

  logic [NibbleW-1:0] a_nib, b_nib, s_nib;
  logic               c_nib;
  logic               ovf_d;

  // Select the current nibble of each latched operand; B is inverted for subtract.
  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int i = 0; i < int'(NIBBLES); i++) begin
      if (idx_q == IdxW'(i)) begin
        a_nib = a_q[NibbleW*i +: NibbleW];
        b_nib = b_q[NibbleW*i +: NibbleW] ^ {NibbleW{sub_q}};
      end
    end
  end

  nibble_add_cin u_slice (
    .a_i    (a_nib),
    .b_i    (b_nib),
    .cin_i  (carry_q),
    .s_o    (s_nib),
    .cout_o (c_nib)
  );

  // Merge the fresh nibble into the working word; also form signed overflow from the MSB nibble.
  always_comb begin
    work_d = work_q;
    for (int i = 0; i < int'(NIBBLES); i++) begin
      if (idx_q == IdxW'(i)) begin
        work_d[NibbleW*i +: NibbleW] = s_nib;
      end
    end
    ovf_d = (a_q[W-1] == (b_q[W-1] ^ sub_q)) && (s_nib[NibbleW-1] != a_q[W-1]);
  end

  // Control FSM, datapath registers and registered outputs; outputs update only at done.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      sub_q       <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      work_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            a_q     <= op_a_i;
            b_q     <= op_b_i;
            sub_q   <= sub_i;
            carry_q <= sub_i;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StRun;
          end
        end
        StRun: begin
          work_q  <= work_d;
          carry_q <= c_nib;
          idx_q   <= idx_q + 1'b1;
          if (idx_q == LastIdx) begin
            idx_q       <= '0;
            state_q     <= StIdle;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            result_q    <= work_d;
            carry_out_q <= c_nib;
            overflow_q  <= ovf_d;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign result_o    = result_q;
  assign carry_out_o = carry_out_q;
  assign overflow_o  = overflow_q;

endmodule
